uart_cmd_framer: RTL and testbench
==================================

Name: uart_cmd_framer

Overview:
- Sits between the host-side UART and the DSO command dispatcher inside DSO_dig.
- Receive path: collects three consecutive UART bytes (opcode, byte2, byte3) into one 24-bit command and presents it with a ready/clear handshake.
- Transmit path: takes single response bytes from the dispatcher (0xA5 ack, read data, dump samples) and drives the UART transmitter one byte at a time.
- An inter-byte timeout resynchronises framing if the host stalls mid-command.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles allowed between bytes of one command before the partial command is discarded. Must be ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_rdy  in  1  UART has a received byte; level, held until cleared
- rx_data  in  8  received byte, valid while rx_rdy=1
- clr_rx_rdy  out  1  clears UART rx_rdy; combinational
- cmd  out  24  assembled command {opcode, byte2, byte3}
- cmd_rdy  out  1  cmd valid; held until clr_cmd_rdy
- cmd_bad_op  out  1  opcode not in 0x01..0x09; valid while cmd_rdy=1
- clr_cmd_rdy  in  1  dispatcher consumed cmd
- frame_err  out  1  one-cycle pulse on inter-byte timeout
- send_resp  in  1  one-cycle request to send resp_data
- resp_data  in  8  response byte, sampled when send_resp=1
- trmt  out  1  one-cycle UART transmit strobe
- tx_data  out  8  byte to UART transmitter
- tx_done  in  1  UART transmit complete; level, rises at end of byte
- resp_busy  out  1  byte in flight; send_resp ignored while high
- resp_sent  out  1  one-cycle pulse when the byte has been transmitted

Behaviour:
- Reset (async, rst=1): all registers, cmd, tx_data and counters go to 0. cmd_rdy, cmd_bad_op, frame_err, trmt, resp_busy, resp_sent and clr_rx_rdy are 0. Both FSMs enter their first state.
- RX FSM states: WAIT_OP, WAIT_B2, WAIT_B3, HOLD.
  - In a WAIT_* state with rx_rdy=1: clr_rx_rdy=1 in the same cycle. rx_data is captured into the matching byte of cmd at the edge, and the FSM advances (OP→B2→B3→HOLD). The timeout counter clears to 0.
  - Capture of byte3 enters HOLD; cmd_rdy=1 from the next cycle, so latency from byte3 rx_rdy to cmd_rdy is 1 cycle.
  - cmd_bad_op is registered with byte3 capture.
  - HOLD: rx_rdy is ignored (clr_rx_rdy=0) and the byte stays pending in the UART. cmd stays stable.
  - clr_cmd_rdy=1 in HOLD: cmd_rdy drops next cycle and the FSM returns to WAIT_OP. A pending rx_rdy may be captured in the cycle after the return.
  - clr_cmd_rdy outside HOLD is ignored.
- Timeout:
  - Counter increments each cycle in WAIT_B2 or WAIT_B3 while rx_rdy=0. It holds at 0 in WAIT_OP and HOLD.
  - When the counter reaches TIMEOUT_CYCLES-1: next state is WAIT_OP, frame_err pulses one cycle, and the partial cmd bytes are left as-is (cmd_rdy stays 0).
  - rx_rdy=1 in the same cycle as expiry wins: the byte is captured and no timeout occurs.
- TX FSM states: TX_IDLE, TX_BUSY.
  - TX_IDLE with send_resp=1: tx_data<=resp_data, trmt=1 for exactly the next cycle, resp_busy=1 from the next cycle, enter TX_BUSY.
  - TX_BUSY: tx_done is edge-detected with a registered copy. On the rising edge: resp_sent pulses one cycle, resp_busy drops, return to TX_IDLE.
  - A tx_done already high on entry is not an edge.
  - send_resp during TX_BUSY is dropped; no queue. The dispatcher must wait for resp_sent.
  - send_resp on the same cycle as resp_sent is dropped.
- RX and TX paths are fully independent; simultaneous activity is legal.
- Reset mid-frame or mid-transmit discards all state. The UART is not cleared by rst.

Decomposition:
- Package dso_cmd_pkg holds:
  - rx_state_t and tx_state_t enums.
  - Opcode localparams: DUMP_CH 0x01, CFG_GAIN 0x02, TRIG_LVL 0x03, TRIG_POS 0x04, SET_DEC 0x05, TRIG_CFG 0x06, TRIG_RD 0x07, EEP_WRT 0x08, EEP_RD 0x09.
  - Response constants POS_ACK 0xA5 and NEG_ACK 0xEE.
- Sub-module resp_tx_ctrl (TX FSM plus tx_done edge detect) is natural.
- RX FSM and timeout counter stay in the top module.

Test Plan:
- Bytes 0x02, 0x1C, 0x00 with rx_rdy held until clr_rx_rdy → three single-cycle clr_rx_rdy pulses; cmd=0x021C00 and cmd_rdy=1 one cycle after the third byte; cmd_bad_op=0.
- Hold cmd_rdy, then present byte 0x08 → clr_rx_rdy stays 0 and cmd stays 0x021C00. Pulse clr_cmd_rdy → cmd_rdy=0 next cycle, 0x08 is captured the following cycle as the opcode.
- TIMEOUT_CYCLES=16: send 0x03, stall 16 cycles → frame_err pulse at cycle 15 after the byte. Then 0x04, 0x00, 0x80 → cmd=0x040080.
- Byte arrives exactly on the expiry cycle → captured, no frame_err.
- Opcode 0x0A, 0x00, 0x00 → cmd_rdy=1 with cmd_bad_op=1.
- send_resp with resp_data=0xA5 → tx_data=0xA5 and one trmt pulse. A second send_resp (0x99) while resp_busy=1 → ignored. tx_done rising → resp_sent pulse, resp_busy=0. Assert rst mid-transmit → all outputs 0 immediately.

Source files
------------

// File: rtl/dso_cmd_pkg.sv
// Shared DSO command/response definitions: framer FSM states, opcodes, ack bytes.
package dso_cmd_pkg;

   typedef enum logic [1:0] {WAIT_OP, WAIT_B2, WAIT_B3, HOLD} rx_state_t;
   typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;

   localparam logic [7:0] DUMP_CH  = 8'h01;
   localparam logic [7:0] CFG_GAIN = 8'h02;
   localparam logic [7:0] TRIG_LVL = 8'h03;
   localparam logic [7:0] TRIG_POS = 8'h04;
   localparam logic [7:0] SET_DEC  = 8'h05;
   localparam logic [7:0] TRIG_CFG = 8'h06;
   localparam logic [7:0] TRIG_RD  = 8'h07;
   localparam logic [7:0] EEP_WRT  = 8'h08;
   localparam logic [7:0] EEP_RD   = 8'h09;

   localparam logic [7:0] POS_ACK  = 8'hA5;
   localparam logic [7:0] NEG_ACK  = 8'hEE;

   // Opcodes form one contiguous range, DUMP_CH..EEP_RD.
   function automatic logic op_valid(input logic [7:0] op);
      return (op >= DUMP_CH) && (op <= EEP_RD);
   endfunction

endpackage

// File: rtl/resp_tx_ctrl.sv
// Single-byte response sender: one trmt strobe per accepted byte, busy until the
// UART's tx_done level rises.
module resp_tx_ctrl
   import dso_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       send_resp,
   input  logic [7:0] resp_data,
   input  logic       tx_done,
   output logic       trmt,
   output logic [7:0] tx_data,
   output logic       resp_busy,
   output logic       resp_sent
);

   tx_state_t tx_state;
   logic      done_q;
   logic      done_rise;

   // done_q follows tx_done in every state so a level already high on entry is no edge
   assign done_rise = tx_done && !done_q;
   assign resp_busy = (tx_state == TX_BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state  <= TX_IDLE;
         tx_data   <= '0;
         trmt      <= 1'b0;
         resp_sent <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= tx_done;
         trmt      <= 1'b0;
         resp_sent <= 1'b0;
         case (tx_state)
            TX_IDLE: if (send_resp && !resp_sent) begin
               tx_data  <= resp_data;
               trmt     <= 1'b1;
               tx_state <= TX_BUSY;
            end
            TX_BUSY: if (done_rise) begin
               resp_sent <= 1'b1;
               tx_state  <= TX_IDLE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames three UART bytes into a 24-bit DSO command with an inter-byte timeout,
// and hands single response bytes to the UART transmitter.
module uart_cmd_framer
   import dso_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   output logic        cmd_bad_op,
   input  logic        clr_cmd_rdy,
   output logic        frame_err,
   input  logic        send_resp,
   input  logic [7:0]  resp_data,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        resp_busy,
   output logic        resp_sent
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   rx_state_t     rx_state;
   logic [TW-1:0] tcnt;
   logic          capture;
   logic          expire;

   assign capture    = rx_rdy && (rx_state != HOLD);
   // held low during reset so the UART never loses a byte while we are in reset
   assign clr_rx_rdy = capture && !rst;
   assign expire     = (rx_state == WAIT_B2 || rx_state == WAIT_B3) && !rx_rdy &&
                       (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign frame_err  = expire;
   assign cmd_rdy    = (rx_state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= WAIT_OP;
         cmd        <= '0;
         cmd_bad_op <= 1'b0;
         tcnt       <= '0;
      end else begin
         case (rx_state)
            WAIT_OP: begin
               tcnt <= '0;
               if (rx_rdy) begin
                  cmd[23:16] <= rx_data;
                  rx_state   <= WAIT_B2;
               end
            end
            WAIT_B2: begin
               if (rx_rdy) begin
                  cmd[15:8] <= rx_data;
                  rx_state  <= WAIT_B3;
                  tcnt      <= '0;
               end else if (expire) begin
                  rx_state <= WAIT_OP;
                  tcnt     <= '0;
               end else
                  tcnt <= tcnt + TW'(1);
            end
            WAIT_B3: begin
               if (rx_rdy) begin
                  cmd[7:0]   <= rx_data;
                  cmd_bad_op <= !op_valid(cmd[23:16]);
                  rx_state   <= HOLD;
                  tcnt       <= '0;
               end else if (expire) begin
                  // partial bytes stay in cmd; cmd_rdy never rises for them
                  rx_state <= WAIT_OP;
                  tcnt     <= '0;
               end else
                  tcnt <= tcnt + TW'(1);
            end
            HOLD: begin
               tcnt <= '0;
               if (clr_cmd_rdy) rx_state <= WAIT_OP;
            end
            default: rx_state <= WAIT_OP;
         endcase
      end
   end

   resp_tx_ctrl u_tx (
      .clk       (clk),
      .rst       (rst),
      .send_resp (send_resp),
      .resp_data (resp_data),
      .tx_done   (tx_done),
      .trmt      (trmt),
      .tx_data   (tx_data),
      .resp_busy (resp_busy),
      .resp_sent (resp_sent)
   );

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: byte-count/queue style model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_cmd_framer;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        clr_rx_rdy;
   logic [23:0] cmd;
   logic        cmd_rdy, cmd_bad_op;
   logic        clr_cmd_rdy = 1'b0;
   logic        frame_err;
   logic        send_resp = 1'b0;
   logic [7:0]  resp_data = 8'h00;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b1;
   logic        resp_busy, resp_sent;

   uart_cmd_framer #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
      .cmd(cmd), .cmd_rdy(cmd_rdy), .cmd_bad_op(cmd_bad_op), .clr_cmd_rdy(clr_cmd_rdy),
      .frame_err(frame_err), .send_resp(send_resp), .resp_data(resp_data), .trmt(trmt),
      .tx_data(tx_data), .tx_done(tx_done), .resp_busy(resp_busy), .resp_sent(resp_sent)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // model: m_n = bytes collected so far (3 = command waiting for the dispatcher)
   int          m_n, m_sil;
   logic [23:0] m_cmd;
   logic        m_bad, m_busy, m_trmt, m_sent, m_prev;
   logic [7:0]  m_txd;
   logic        last_fe;
   int          clr_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_sil = 0; m_cmd = '0; m_bad = 0;
      m_busy = 0; m_trmt = 0; m_sent = 0; m_prev = 0; m_txd = '0;
   endtask

   // Called at posedge+1 with inputs set; checks at negedge, advances model, returns at next posedge+1.
   task automatic tick();
      logic e_clr, e_fe, rise, acc;
      @(negedge clk);
      e_clr = rx_rdy && (m_n < 3);
      e_fe  = (m_n == 1 || m_n == 2) && !rx_rdy && (m_sil == T - 1);
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(e_clr));
      chk("cmd_rdy",    32'(cmd_rdy),    32'(m_n == 3));
      chk("cmd",        32'(cmd),        32'(m_cmd));
      if (m_n == 3) chk("cmd_bad_op", 32'(cmd_bad_op), 32'(m_bad));
      chk("frame_err",  32'(frame_err),  32'(e_fe));
      chk("trmt",       32'(trmt),       32'(m_trmt));
      chk("tx_data",    32'(tx_data),    32'(m_txd));
      chk("resp_busy",  32'(resp_busy),  32'(m_busy));
      chk("resp_sent",  32'(resp_sent),  32'(m_sent));
      last_fe = frame_err;
      if (clr_rx_rdy) clr_cnt++;
      if (e_clr) begin
         m_cmd[23 - 8*m_n -: 8] = rx_data;
         if (m_n == 2) m_bad = !(m_cmd[23:16] >= 8'd1 && m_cmd[23:16] <= 8'd9);
         m_n++;
         m_sil = 0;
      end else if (e_fe) begin
         m_n = 0; m_sil = 0;
      end else if (m_n == 1 || m_n == 2) m_sil++;
      else if (m_n == 3 && clr_cmd_rdy) m_n = 0;
      rise   = tx_done && !m_prev;
      m_prev = tx_done;
      acc    = !m_busy && send_resp && !m_sent;
      m_trmt = acc;
      m_sent = m_busy && rise;
      if (acc) begin m_busy = 1; m_txd = resp_data; end
      else if (m_sent) m_busy = 0;
      @(posedge clk);
      #1;
      if (e_clr) rx_rdy = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      for (int i = 0; i < 8 && rx_rdy; i++) tick();
      chk("rx_consumed", 32'(rx_rdy), 32'd0);
   endtask

   task automatic release_cmd();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      int fe_cnt, fe_at, gap;
      model_reset();
      clr_cnt = 0;
      #12;
      chk("rst_cmd",     32'(cmd), 32'd0);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("rst_trmt",    32'(trmt), 32'd0);
      chk("rst_busy",    32'(resp_busy), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // three-byte command
      put_byte(8'h02); put_byte(8'h1C); put_byte(8'h00);
      chk("cmd_021C00", 32'(cmd), 32'h021C00);
      chk("cmd_rdy_1",  32'(cmd_rdy), 32'd1);
      chk("bad_op_0",   32'(cmd_bad_op), 32'd0);
      chk("clr_pulses", 32'(clr_cnt), 32'd3);

      // byte pending while holding
      rx_data = 8'h08; rx_rdy = 1'b1;
      repeat (3) tick();
      chk("hold_cmd",     32'(cmd), 32'h021C00);
      chk("hold_pending", 32'(rx_rdy), 32'd1);
      release_cmd();
      chk("cmd_rdy_drop",  32'(cmd_rdy), 32'd0);
      chk("clr_after_ret", 32'(clr_rx_rdy), 32'd1);
      tick();
      chk("op_08", 32'(cmd[23:16]), 32'h08);
      put_byte(8'h00); put_byte(8'h00);
      chk("cmd_080000", 32'(cmd), 32'h080000);
      release_cmd();

      // timeout after opcode
      put_byte(8'h03);
      fe_cnt = 0; fe_at = -1;
      for (int i = 0; i < T; i++) begin
         tick();
         if (last_fe) begin fe_cnt++; fe_at = i; end
      end
      chk("fe_cycle",   32'(fe_at), 32'(T - 1));
      chk("fe_count",   32'(fe_cnt), 32'd1);
      chk("fe_partial", 32'(cmd), 32'h030000);
      chk("fe_no_rdy",  32'(cmd_rdy), 32'd0);
      put_byte(8'h04); put_byte(8'h00); put_byte(8'h80);
      chk("cmd_040080", 32'(cmd), 32'h040080);
      release_cmd();

      // byte arriving on the expiry cycle wins
      put_byte(8'h03);
      fe_cnt = 0;
      for (int i = 0; i < T - 1; i++) begin tick(); if (last_fe) fe_cnt++; end
      rx_data = 8'h05; rx_rdy = 1'b1;
      tick();
      if (last_fe) fe_cnt++;
      chk("expiry_no_fe",   32'(fe_cnt), 32'd0);
      chk("expiry_capture", 32'(rx_rdy), 32'd0);
      put_byte(8'h07);
      chk("cmd_030507", 32'(cmd), 32'h030507);
      chk("rdy_030507", 32'(cmd_rdy), 32'd1);
      release_cmd();

      // illegal opcode
      put_byte(8'h0A); put_byte(8'h00); put_byte(8'h00);
      chk("bad_rdy", 32'(cmd_rdy), 32'd1);
      chk("bad_op",  32'(cmd_bad_op), 32'd1);
      release_cmd();

      // response path
      resp_data = 8'hA5; send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("trmt_1",  32'(trmt), 32'd1);
      chk("tx_A5",   32'(tx_data), 32'hA5);
      chk("busy_1",  32'(resp_busy), 32'd1);
      resp_data = 8'h99; send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("trmt_once", 32'(trmt), 32'd0);
      chk("tx_kept",   32'(tx_data), 32'hA5);
      repeat (3) tick();
      chk("high_no_edge", 32'(resp_busy), 32'd1);
      tx_done = 1'b0; tick();
      tx_done = 1'b1; tick();
      chk("resp_sent_1", 32'(resp_sent), 32'd1);
      chk("busy_0",      32'(resp_busy), 32'd0);
      tick();
      chk("resp_sent_0", 32'(resp_sent), 32'd0);

      // reset mid-transmit with a byte pending at the UART
      resp_data = 8'h3C; send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("busy_pre_rst", 32'(resp_busy), 32'd1);
      rx_data = 8'h11; rx_rdy = 1'b1;
      rst = 1'b1;
      #1;
      chk("mrst_trmt", 32'(trmt), 32'd0);
      chk("mrst_busy", 32'(resp_busy), 32'd0);
      chk("mrst_tx",   32'(tx_data), 32'd0);
      chk("mrst_cmd",  32'(cmd), 32'd0);
      chk("mrst_clr",  32'(clr_rx_rdy), 32'd0);
      chk("mrst_sent", 32'(resp_sent), 32'd0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;

      // randomized traffic on both paths
      gap = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!rx_rdy) begin
            if (gap > 0) gap--;
            else begin
               rx_data = ($urandom % 2 == 0) ? 8'($urandom_range(0, 11)) : 8'($urandom);
               rx_rdy  = 1'b1;
               gap = ($urandom % 8 == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            end
         end
         clr_cmd_rdy = ($urandom % 4 == 0);
         send_resp   = ($urandom % 3 == 0);
         resp_data   = 8'($urandom);
         if ($urandom % 4 == 0) tx_done = ~tx_done;
         if (n == 1500) begin
            rst = 1'b1;
            #1;
            chk("rrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
            chk("rrst_busy",    32'(resp_busy), 32'd0);
            model_reset();
            @(posedge clk); #1 rst = 1'b0;
         end
         tick();
      end
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
